// File: rtl/icache_direct.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : icache_direct
// Purpose  : Direct-mapped instruction cache with one-word lines. It answers
//            fetch reads with a one-cycle done pulse and refills misses one
//            word at a time from the memory controller.
// Ports    : clk, rst (async, active-high)
//            rw_flag/addr/write_data/write_mask -> request from the fetcher
//            read_data/ICache_busy/ICache_done  -> response to the fetcher
//            flush                              -> invalidate all lines
//            mem_rw_flag/mem_addr               -> refill request to memory
//            mem_read_data/mem_busy/mem_done    -> refill reply from memory
// Option   : ICACHE_STATS_EN adds saturating hit_count / miss_count outputs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module icache_direct #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            rw_flag,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [3:0]            write_mask,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  ICache_busy,
  output logic                  ICache_done,
  input  logic                  flush,
  output logic [1:0]            mem_rw_flag,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_busy,
  input  logic                  mem_done
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int c_LINES = 1 << INDEX_BITS;
  localparam int c_TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MISS = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  logic [c_LINES-1:0]      r_valid;
  logic [c_TAG_W-1:0]      r_tag  [c_LINES];
  logic [DATA_WIDTH-1:0]   r_data [c_LINES];
  logic [ADDR_WIDTH-3:0]   r_miss_waddr;
  // Remembers a flush seen at any point during the refill so the
  // returned word is delivered but never marked valid.
  logic                    r_flush_seen;

  logic [INDEX_BITS-1:0]   w_idx;
  logic [c_TAG_W-1:0]      w_tag;
  logic                    w_hit;
  logic                    w_accept;
  logic [INDEX_BITS-1:0]   w_fill_idx;
  logic [c_TAG_W-1:0]      w_fill_tag;
  logic                    w_fill;
  logic                    w_unused;

  assign w_idx      = addr[INDEX_BITS+1:2];
  assign w_tag      = addr[ADDR_WIDTH-1:INDEX_BITS+2];
  // A flush on the lookup edge wins, turning the lookup into a miss.
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !flush;
  assign w_accept   = (r_state == S_IDLE) && rw_flag[0];
  assign w_fill_idx = r_miss_waddr[INDEX_BITS-1:0];
  assign w_fill_tag = r_miss_waddr[ADDR_WIDTH-3:INDEX_BITS];
  assign w_fill     = (r_state == S_MISS) && mem_done;

  // Write path, byte offset, write-request bit and memory busy carry no meaning here.
  assign w_unused = ^{write_data, write_mask, mem_busy, addr[1:0], rw_flag[1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_miss_waddr <= '0;
      r_flush_seen <= 1'b0;
      read_data    <= '0;
      ICache_busy  <= 1'b0;
      ICache_done  <= 1'b0;
      mem_rw_flag  <= 2'b00;
      mem_addr     <= '0;
    end else begin
      ICache_done <= 1'b0;
      if (flush) begin
        r_valid <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_hit) begin
              ICache_done <= 1'b1;
              read_data   <= r_data[w_idx];
            end else begin
              r_miss_waddr <= addr[ADDR_WIDTH-1:2];
              r_flush_seen <= 1'b0;
              ICache_busy  <= 1'b1;
              mem_rw_flag  <= 2'b01;
              mem_addr     <= {addr[ADDR_WIDTH-1:2], 2'b00};
              r_state      <= S_MISS;
            end
          end
        end
        S_MISS: begin
          if (flush) begin
            r_flush_seen <= 1'b1;
          end
          if (mem_done) begin
            if (!flush && !r_flush_seen) begin
              r_valid[w_fill_idx] <= 1'b1;
            end
            read_data   <= mem_read_data;
            ICache_done <= 1'b1;
            ICache_busy <= 1'b0;
            mem_rw_flag <= 2'b00;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem_read_data;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (w_accept) begin
      if (w_hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_direct.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_icache_direct
// Purpose  : Directed self-checking bench for icache_direct. The bench plays
//            both the fetcher and the memory controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_icache_direct;

  logic        clk;
  logic        rst;
  logic [1:0]  rw_flag;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [3:0]  write_mask;
  logic [31:0] read_data;
  logic        ICache_busy;
  logic        ICache_done;
  logic        flush;
  logic [1:0]  mem_rw_flag;
  logic [31:0] mem_addr;
  logic [31:0] mem_read_data;
  logic        mem_busy;
  logic        mem_done;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int total = 0;
  int bad   = 0;

  icache_direct #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .INDEX_BITS(7)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rw_flag      (rw_flag),
    .addr         (addr),
    .write_data   (write_data),
    .write_mask   (write_mask),
    .read_data    (read_data),
    .ICache_busy  (ICache_busy),
    .ICache_done  (ICache_done),
    .flush        (flush),
    .mem_rw_flag  (mem_rw_flag),
    .mem_addr     (mem_addr),
    .mem_read_data(mem_read_data),
    .mem_busy     (mem_busy),
    .mem_done     (mem_done)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One fetch transaction. For a miss the bench answers as memory with
  // 'word' after 'lat' cycles (lat >= 2); fl_mid pulses flush inside MISS.
  task automatic do_read(input logic [31:0] a, input logic [1:0] rw, input bit hit,
                         input logic [31:0] word, input int lat, input bit fl_mid);
    @(negedge clk);
    rw_flag = rw;
    addr    = a;
    @(negedge clk);
    rw_flag = 2'b00;
    if (hit) begin
      chk("hit_done",  {31'd0, ICache_done}, 32'd1);
      chk("hit_data",  read_data, word);
      chk("hit_busy",  {31'd0, ICache_busy}, 32'd0);
      chk("hit_memrw", {30'd0, mem_rw_flag}, 32'd0);
      @(negedge clk);
      chk("hit_done_drop", {31'd0, ICache_done}, 32'd0);
    end else begin
      chk("miss_busy",  {31'd0, ICache_busy}, 32'd1);
      chk("miss_memrw", {30'd0, mem_rw_flag}, 32'd1);
      chk("miss_addr",  mem_addr, {a[31:2], 2'b00});
      chk("miss_nodone", {31'd0, ICache_done}, 32'd0);
      flush = fl_mid;
      @(negedge clk);
      flush = 1'b0;
      repeat (lat - 2) @(negedge clk);
      chk("miss_hold_addr", mem_addr, {a[31:2], 2'b00});
      mem_done      = 1'b1;
      mem_read_data = word;
      @(negedge clk);
      mem_done      = 1'b0;
      mem_read_data = 32'hDEAD_BEEF;
      chk("resp_done",  {31'd0, ICache_done}, 32'd1);
      chk("resp_data",  read_data, word);
      chk("resp_busy",  {31'd0, ICache_busy}, 32'd0);
      chk("resp_memrw", {30'd0, mem_rw_flag}, 32'd0);
      @(negedge clk);
      chk("resp_done_drop", {31'd0, ICache_done}, 32'd0);
    end
  endtask

  initial begin
    rst           = 1'b1;
    rw_flag       = 2'b00;
    addr          = 32'd0;
    write_data    = 32'd0;
    write_mask    = 4'd0;
    flush         = 1'b0;
    mem_read_data = 32'd0;
    mem_busy      = 1'b0;
    mem_done      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_done",  {31'd0, ICache_done}, 32'd0);
    chk("rst_busy",  {31'd0, ICache_busy}, 32'd0);
    chk("rst_memrw", {30'd0, mem_rw_flag}, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    rst = 1'b0;

    // Cold miss, then hits (including unaligned byte address and rw=11).
    do_read(32'h0000_0004, 2'b01, 1'b0, 32'h00A0_0093, 3, 1'b0);
    do_read(32'h0000_0004, 2'b01, 1'b1, 32'h00A0_0093, 0, 1'b0);
    do_read(32'h0000_0007, 2'b01, 1'b1, 32'h00A0_0093, 0, 1'b0);
    do_read(32'h0000_0004, 2'b11, 1'b1, 32'h00A0_0093, 0, 1'b0);

    // Write-only and idle request codes are ignored.
    @(negedge clk);
    rw_flag = 2'b10;
    addr    = 32'h0000_0004;
    @(negedge clk);
    rw_flag = 2'b00;
    chk("wr_nodone", {31'd0, ICache_done}, 32'd0);
    chk("wr_nomem",  {30'd0, mem_rw_flag}, 32'd0);
    @(negedge clk);
    chk("idle_nodone", {31'd0, ICache_done}, 32'd0);
    chk("idle_nobusy", {31'd0, ICache_busy}, 32'd0);

    // Conflict on index 1: 0x204 evicts 0x4, which then misses again.
    do_read(32'h0000_0204, 2'b01, 1'b0, 32'h0010_0113, 2, 1'b0);
    do_read(32'h0000_0204, 2'b01, 1'b1, 32'h0010_0113, 0, 1'b0);
    do_read(32'h0000_0004, 2'b01, 1'b0, 32'h00A0_0093, 4, 1'b0);

    // Flush in IDLE invalidates the valid line.
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    do_read(32'h0000_0004, 2'b01, 1'b0, 32'h00A0_0093, 2, 1'b0);
    do_read(32'h0000_0004, 2'b01, 1'b1, 32'h00A0_0093, 0, 1'b0);

    // Flush during MISS: word still returned, line left invalid.
    do_read(32'h0000_0008, 2'b01, 1'b0, 32'h1234_5678, 3, 1'b1);
    do_read(32'h0000_0008, 2'b01, 1'b0, 32'h1234_5678, 2, 1'b0);
    do_read(32'h0000_0008, 2'b01, 1'b1, 32'h1234_5678, 0, 1'b0);

    // Reset in the middle of a refill.
    @(negedge clk);
    rw_flag = 2'b01;
    addr    = 32'h0000_000C;
    @(negedge clk);
    rw_flag = 2'b00;
    chk("mr_busy", {31'd0, ICache_busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_rst_busy",  {31'd0, ICache_busy}, 32'd0);
    chk("mr_rst_memrw", {30'd0, mem_rw_flag}, 32'd0);
    chk("mr_rst_maddr", mem_addr, 32'd0);
    chk("mr_rst_rdata", read_data, 32'd0);
    @(negedge clk);
    rst           = 1'b0;
    mem_done      = 1'b1;
    mem_read_data = 32'hCAFE_F00D;
    @(negedge clk);
    mem_done = 1'b0;
    chk("mr_late_nodone", {31'd0, ICache_done}, 32'd0);
    chk("mr_late_nobusy", {31'd0, ICache_busy}, 32'd0);
    do_read(32'h0000_000C, 2'b01, 1'b0, 32'h0000_0013, 2, 1'b0);
    do_read(32'h0000_0008, 2'b01, 1'b0, 32'h1234_5678, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
